// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one Avalon-style SDRAM controller port between
// a playback reader and a recording writer. A granted command is latched in
// IDLE, issued in ISSUE, (for reads) completed in WAIT_DATA, and acknowledged
// with a one-cycle finished pulse in DONE. A watchdog aborts transactions the
// SDRAM never completes and leaves a sticky error flag behind.
//
// Client handshake (valid/ready style): a client raises its request level
// together with stable command fields and holds it until it sees its one-cycle
// finished pulse. The command is captured on the grant edge, so later changes
// to the request or its fields do not affect the transaction in flight. On the
// SDRAM side a strobe is held with stable address/data until the controller
// takes it, i.e. the first cycle the strobe is high with waitrequest low.
module sdram_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              play_read,
    input  logic [ADDR_W-1:0] play_addr,
    output logic [DATA_W-1:0] play_readdata,
    output logic              play_sdram_finished,
    input  logic              rec_write,
    input  logic [ADDR_W-1:0] rec_addr,
    input  logic [DATA_W-1:0] rec_writedata,
    output logic              rec_sdram_finished,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_read,
    output logic              sdram_write,
    output logic [DATA_W-1:0] sdram_writedata,
    input  logic [DATA_W-1:0] sdram_readdata,
    input  logic              sdram_waitrequest,
    input  logic              sdram_readdatavalid,
    output logic              busy,
    output logic              err_timeout
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    // The granted client also encodes the operation: playback reads, recorder writes.
    logic              grant_rec;
    logic              last_rec;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [WD_W-1:0]   wd_cnt;
    logic              err_q;

    logic              take_grant;
    logic              take_rec;
    logic              capture_data;
    logic              abort;
    logic              wd_expired;

    // The current cycle is the last one the watchdog allows in ISSUE/WAIT_DATA.
    assign wd_expired = (wd_cnt == WD_LAST);

    // Next-state and control decode; completion takes precedence over abort in the final cycle.
    always_comb begin
        state_next   = state;
        take_grant   = 1'b0;
        take_rec     = 1'b0;
        capture_data = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (play_read || rec_write) begin
                    take_grant = 1'b1;
                    // On a tie the recorder wins only if playback was served last.
                    take_rec   = rec_write && (!play_read || !last_rec);
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!sdram_waitrequest) begin
                    state_next = grant_rec ? DONE : WAIT_DATA;
                end else if (wd_expired) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            WAIT_DATA: begin
                if (sdram_readdatavalid) begin
                    capture_data = 1'b1;
                    state_next   = DONE;
                end else if (wd_expired) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command latch, round-robin history, watchdog, read data and sticky error.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant_rec <= 1'b0;
            last_rec  <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wd_cnt    <= '0;
            err_q     <= 1'b0;
        end else begin
            if (take_grant) begin
                grant_rec <= take_rec;
                addr_q    <= take_rec ? rec_addr : play_addr;
                if (take_rec) begin
                    wdata_q <= rec_writedata;
                end
                wd_cnt <= '0;
            end else if (state == ISSUE || state == WAIT_DATA) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (capture_data) begin
                rdata_q <= sdram_readdata;
            end
            if (abort) begin
                err_q <= 1'b1;
                if (!grant_rec) begin
                    rdata_q <= '0;
                end
            end
            if (state == DONE) begin
                last_rec <= grant_rec;
            end
        end
    end

    assign sdram_read          = (state == ISSUE) && !grant_rec;
    assign sdram_write         = (state == ISSUE) && grant_rec;
    assign sdram_addr          = addr_q;
    assign sdram_writedata     = wdata_q;
    assign play_readdata       = rdata_q;
    assign play_sdram_finished = (state == DONE) && !grant_rec;
    assign rec_sdram_finished  = (state == DONE) && grant_rec;
    assign busy                = (state != IDLE);
    assign err_timeout         = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus a randomized phase, checked
// against a transaction-level model of arbitration order, completion latency,
// read data and the sticky timeout flag.
module tb_sdram_arbiter;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          play_read;
  logic [AW-1:0] play_addr;
  logic [DW-1:0] play_readdata;
  logic          play_sdram_finished;
  logic          rec_write;
  logic [AW-1:0] rec_addr;
  logic [DW-1:0] rec_writedata;
  logic          rec_sdram_finished;
  logic [AW-1:0] sdram_addr;
  logic          sdram_read;
  logic          sdram_write;
  logic [DW-1:0] sdram_writedata;
  logic [DW-1:0] sdram_readdata;
  logic          sdram_waitrequest;
  logic          sdram_readdatavalid;
  logic          busy;
  logic          err_timeout;

  int checks = 0;
  int errors = 0;

  // Model state: who was served last, what playback last read, sticky error.
  bit            m_last_rec;
  logic [DW-1:0] m_rdata;
  bit            m_err;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .play_read           (play_read),
    .play_addr           (play_addr),
    .play_readdata       (play_readdata),
    .play_sdram_finished (play_sdram_finished),
    .rec_write           (rec_write),
    .rec_addr            (rec_addr),
    .rec_writedata       (rec_writedata),
    .rec_sdram_finished  (rec_sdram_finished),
    .sdram_addr          (sdram_addr),
    .sdram_read          (sdram_read),
    .sdram_write         (sdram_write),
    .sdram_writedata     (sdram_writedata),
    .sdram_readdata      (sdram_readdata),
    .sdram_waitrequest   (sdram_waitrequest),
    .sdram_readdatavalid (sdram_readdatavalid),
    .busy                (busy),
    .err_timeout         (err_timeout)
  );

  // Clock.
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One client transaction with a reactive SDRAM responder. Called at posedge+1
  // with the DUT idle; cycle 0 is the cycle in which the requests appear.
  // stall = waitrequest cycles before accept; dly = cycles from accept to
  // readdatavalid (0 = data never returns).
  task automatic txn(input bit p, input bit r, input int stall, input int dly,
                     input bit drop_early, input bit wiggle,
                     input logic [AW-1:0] pa, input logic [AW-1:0] ra,
                     input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    bit            win_rec;
    bit            abort_exp;
    int            exp_fin;
    int            exp_strobes;
    logic [DW-1:0] exp_rd;
    bit            exp_err;
    int            strobes = 0;
    int            fin = -1;
    int            pf = 0;
    int            rf = 0;
    int            stall_left = stall;
    int            dv_at = -1;
    bit            spur;
    bit            strobe;

    // Reference model: round robin on ties, otherwise whoever asks.
    if (p && r) win_rec = !m_last_rec;
    else        win_rec = r;
    if (win_rec) begin
      abort_exp = (stall + 1 > TO);
      exp_fin   = abort_exp ? TO + 1 : stall + 2;
    end else begin
      abort_exp = (dly == 0) || (stall + 1 + dly > TO);
      exp_fin   = abort_exp ? TO + 1 : stall + dly + 2;
    end
    exp_strobes = (stall + 1 > TO) ? TO : stall + 1;
    exp_rd      = win_rec ? m_rdata : (abort_exp ? '0 : rd);
    exp_err     = m_err || abort_exp;
    spur        = 1'($urandom_range(0, 1));

    play_read     = p;
    play_addr     = pa;
    rec_write     = r;
    rec_addr      = ra;
    rec_writedata = wd;

    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      strobe              = sdram_read | sdram_write;
      sdram_readdatavalid = (c == dv_at) || (c == 0 && spur);
      sdram_readdata      = (c == dv_at) ? rd : DW'($urandom);
      if (strobe) begin
        strobes++;
        check("strobe_kind", 64'(sdram_write), 64'(win_rec));
        check("strobe_addr", 64'(sdram_addr), 64'(win_rec ? ra : pa));
        if (win_rec) check("strobe_wdata", 64'(sdram_writedata), 64'(wd));
        if (stall_left > 0) begin
          sdram_waitrequest = 1'b1;
          stall_left--;
        end else begin
          sdram_waitrequest = 1'b0;
          if (sdram_read && dly > 0) dv_at = c + dly;
        end
      end else begin
        sdram_waitrequest = 1'($urandom_range(0, 1));
      end
      check("one_strobe", 64'(sdram_read & sdram_write), 64'(0));
      check("fin_excl", 64'(play_sdram_finished & rec_sdram_finished), 64'(0));
      check("fin_vs_strobe", 64'((play_sdram_finished | rec_sdram_finished) & strobe), 64'(0));
      if (c == 0) begin
        check("idle_busy", 64'(busy), 64'(0));
        check("hold_rdata", 64'(play_readdata), 64'(m_rdata));
      end
      if (c == 1) check("active_busy", 64'(busy), 64'(1));
      if (play_sdram_finished) pf++;
      if (rec_sdram_finished) rf++;
      if (fin < 0 && (play_sdram_finished || rec_sdram_finished)) begin
        fin = c;
        check("fin_rdata", 64'(play_readdata), 64'(exp_rd));
        check("fin_err", 64'(err_timeout), 64'(exp_err));
      end
      if (fin >= 0 && c == fin + 1) break;
      @(posedge i_clk);
      #1;
      if (c == 0) begin
        if (drop_early) begin
          if (win_rec) rec_write = 1'b0;
          else         play_read = 1'b0;
        end
        if (wiggle) begin
          play_addr     = AW'($urandom);
          rec_addr      = AW'($urandom);
          rec_writedata = DW'($urandom);
        end
      end
      if (fin >= 0 && c == fin) begin
        play_read = 1'b0;
        rec_write = 1'b0;
      end
    end
    play_read = 1'b0;
    rec_write = 1'b0;

    check("fin_cycle", 64'(fin), 64'(exp_fin));
    check("strobe_cycles", 64'(strobes), 64'(exp_strobes));
    check("fin_winner", 64'(win_rec ? rf : pf), 64'(1));
    check("fin_loser", 64'(win_rec ? pf : rf), 64'(0));

    m_last_rec = win_rec;
    m_err      = exp_err;
    m_rdata    = exp_rd;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, 64'(play_readdata), 64'(0));
    check({tag, "_addr"}, 64'(sdram_addr), 64'(0));
    check({tag, "_wdata"}, 64'(sdram_writedata), 64'(0));
    check({tag, "_ctrl"}, 64'({play_sdram_finished, rec_sdram_finished, sdram_read,
                               sdram_write, busy, err_timeout}), 64'(0));
  endtask

  task automatic rand_txn();
    bit p;
    bit r;
    int stall;
    p = 1'($urandom_range(0, 1));
    r = p ? 1'($urandom_range(0, 1)) : 1'b1;
    stall = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 3);
    txn(p, r, stall, $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
  endtask

  // Stimulus: reset, directed scenarios, random traffic, reset mid-read, report.
  initial begin
    i_rst               = 1'b1;
    play_read           = 1'b0;
    play_addr           = '0;
    rec_write           = 1'b0;
    rec_addr            = '0;
    rec_writedata       = '0;
    sdram_readdata      = '0;
    sdram_waitrequest   = 1'b0;
    sdram_readdatavalid = 1'b0;
    m_last_rec          = 1'b1;
    m_rdata             = '0;
    m_err               = 1'b0;

    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Contention straight after reset: play, rec, play, rec.
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 1'b1, 0, 1, 1'b0, 1'b0, AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
      check("rr_order", 64'(m_last_rec), 64'(i % 2));
    end

    // Single write, no stall.
    txn(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, AW'(0), 23'h000010, 32'hDEADBEEF, 32'h0);
    // Single read, 3 stall cycles, data 2 cycles after accept.
    txn(1'b1, 1'b0, 3, 2, 1'b0, 1'b0, 23'h000020, AW'(0), 32'h0, 32'h12345678);
    check("read_data", 64'(play_readdata), 64'(32'h12345678));
    // Request withdrawn and fields changed after grant.
    txn(1'b1, 1'b0, 1, 1, 1'b1, 1'b1, 23'h000030, AW'(0), 32'h0, 32'hCAFEF00D);
    // Timeout on a read whose data never comes back, then normal traffic.
    txn(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 23'h000040, AW'(0), 32'h0, 32'h55555555);
    check("timeout_rdata", 64'(play_readdata), 64'(0));
    check("timeout_err", 64'(err_timeout), 64'(1));
    txn(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, AW'(0), 23'h000050, 32'h01020304, 32'h0);
    txn(1'b1, 1'b0, 0, 3, 1'b0, 1'b0, 23'h000060, AW'(0), 32'h0, 32'hA5A5A5A5);
    check("err_sticky", 64'(err_timeout), 64'(1));

    // Random traffic.
    for (int i = 0; i < 40; i++) rand_txn();

    // Reset during WAIT_DATA.
    sdram_waitrequest   = 1'b0;
    sdram_readdatavalid = 1'b0;
    play_read           = 1'b1;
    play_addr           = 23'h000070;
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    check("wait_busy", 64'({busy, sdram_read}), 64'(2'b10));
    #2;
    i_rst = 1'b1;
    #1;
    check_all_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("midrst_nofin", 64'({play_sdram_finished, rec_sdram_finished, busy}), 64'(0));
    end
    i_rst     = 1'b0;
    play_read = 1'b0;
    m_last_rec = 1'b1;
    m_rdata    = '0;
    m_err      = 1'b0;
    @(posedge i_clk);
    #1;
    txn(1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 23'h000080, 23'h000090, 32'h11112222, 32'h33334444);
    check("post_rst_tie_play", 64'(m_last_rec), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit in case the DUT wedges the sequence.
  initial begin
    #1000000;
    $display("FAIL global_time_limit observed=expired expected=finished");
    $fatal(1, "time limit");
  end

endmodule
